multicycle_control: RTL and testbench
=====================================

# multicycle_control

Multicycle sequencer for the 32-bit MIPS-subset datapath. Drives the datapath's mux selects, register-file and memory enables, and PC load one state per clock. It replaces single-cycle decode so instruction and data traffic can share one memory port that may stall. It sits between the instruction register/ALU flags and the datapath muxes, and exports an instruction-retired counter for the testbench.

## Interface
- No parameters.
- clk  in  1  system clock; all state changes on posedge.
- rst  in  1  asynchronous, active-high reset.
- opcode  in  6  instruction bits 31:26, from the instruction register.
- zout  in  1  ALU zero flag.
- mem_ready  in  1  memory handshake; the current access completes in a cycle where it is 1.
- pc_en  out  1  PC load enable.
- iord  out  1  memory address select: 0 = PC, 1 = ALU result.
- memread, memwrite  out  1 each  memory strobes.
- irwrite  out  1  instruction register load.
- regdest  out  2  write-register select: 00 = rt, 01 = rd, 10 = r31.
- memtoreg  out  2  write-data select: 00 = ALU, 01 = memory, 10 = PC.
- regwrite  out  1  register file write.
- alusrca  out  1  ALU A select: 0 = PC, 1 = rs.
- alusrcb  out  2  ALU B select: 00 = rt, 01 = 4, 10 = sign-extended immediate, 11 = immediate shifted left 2.
- aluop  out  3  encoding 000 = add, 001 = sub, 010 = use funct.
- pcsource  out  2  next-PC select: 00 = ALU, 01 = ALUOut, 10 = jump address.
- illegal  out  1  one-cycle pulse on an undefined opcode.
- state  out  4  current state, for debug.
- instret  out  32  count of retired instructions.

## Operation
- States use a 4-bit encoding: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXEC 6, RWB 7, BRANCH 8, JUMP 9, JAL 10, ADDIEX 11, ADDIWB 12. Codes 13–15 go to FETCH.
- Outputs are Moore-decoded from the state. Any output not listed for a state is 0.
  - FETCH: memread=1, alusrcb=01, aluop=000, pcsource=00, irwrite=pc_en=mem_ready. Stays in FETCH until mem_ready=1, then goes to DECODE.
  - DECODE: alusrcb=11, aluop=000. Next state by opcode: 0x00 → EXEC, 0x23/0x2B → MEMADR, 0x04 → BRANCH, 0x02 → JUMP, 0x03 → JAL, 0x08 → ADDIEX. Any other opcode → FETCH with illegal=1.
  - MEMADR and ADDIEX: alusrca=1, alusrcb=10, aluop=000. MEMADR goes to MEMRD for lw, MEMWR for sw. ADDIEX goes to ADDIWB.
  - MEMRD: memread=1, iord=1. Holds until mem_ready=1, then goes to MEMWB.
  - MEMWB: regwrite=1, memtoreg=01, regdest=00.
  - MEMWR: memwrite=1, iord=1. Holds until mem_ready=1.
  - EXEC: alusrca=1, alusrcb=00, aluop=010, then RWB.
  - RWB: regwrite=1, regdest=01. ADDIWB: regwrite=1, regdest=00.
  - BRANCH: alusrca=1, aluop=001, pcsource=01, pc_en=zout.
  - JUMP: pcsource=10, pc_en=1.
  - JAL: pcsource=10, pc_en=1, regwrite=1, regdest=10, memtoreg=10.
  - MEMWB, MEMWR (on mem_ready), RWB, ADDIWB, BRANCH, JUMP and JAL all return to FETCH and increment instret by 1.
- instret is 32-bit and wraps from 0xFFFFFFFF to 0. An illegal opcode does not count.

## Timing
- Reset:
  - rst=1 immediately forces state=FETCH and instret=0.
  - While rst=1, every enable and strobe output is 0, including pc_en, irwrite, memread, memwrite and regwrite.
  - A reset in mid-instruction abandons the instruction, with no further writes.
  - The first FETCH cycle is the first posedge after rst falls.
- Cycle counts with mem_ready held at 1:
  - lw: 5
  - sw, R-type, addi: 4
  - beq, j, jal: 3
- Each cycle with mem_ready=0 in FETCH, MEMRD or MEMWR adds one cycle. The strobes stay asserted throughout and pc_en/irwrite stay 0.
- illegal is high for exactly the DECODE cycle.
- When a retirement and its instret increment coincide with wrap-around, the counter goes to 0 on that edge.

## Structure
- Shared header ctrl_defs holds:
  - the state codes
  - the opcode constants (R 0x00, LW 0x23, SW 0x2B, BEQ 0x04, J 0x02, JAL 0x03, ADDI 0x08)
  - the aluop, regdest, memtoreg, alusrcb and pcsource encodings
- Sub-module ctrl_outdecode is the combinational state-to-output decoder. The top holds the state register, next-state logic, the reset gating of outputs, and the instret counter.

## Test plan
- rst pulsed during EXEC: state=0, instret=0 and regwrite=0 while rst is high. After release, FETCH asserts memread=1.
- lw (0x23) with mem_ready=1: states 0,1,2,3,4,0 in order. regwrite=1 only in MEMWB with memtoreg=01. instret goes 0→1.
- sw (0x2B) with mem_ready low for 3 cycles in MEMWR: memwrite=1 for 4 cycles. Instruction takes 7 cycles. Exactly one instret increment.
- beq (0x04): with zout=1, pc_en=1 and pcsource=01 in BRANCH. With zout=0, pc_en=0. Either way back to FETCH in 3 cycles.
- jal (0x03): JAL state gives regdest=10, memtoreg=10, regwrite=1, pc_en=1, pcsource=10.
- Opcode 0x3F gives illegal=1 for one cycle, return to FETCH, no instret change. Separately, preload instret to 0xFFFFFFFF and run j (0x02): instret becomes 0.

Source files
------------

// File: rtl/ctrl_defs.sv
// Shared constants for the multicycle MIPS-subset controller: state codes,
// opcodes, datapath select encodings and the bundled control-word type.
package ctrl_defs;

  // State codes (4-bit; 13..15 are unused and recover to FETCH)
  localparam logic [3:0] S_FETCH  = 4'd0;
  localparam logic [3:0] S_DECODE = 4'd1;
  localparam logic [3:0] S_MEMADR = 4'd2;
  localparam logic [3:0] S_MEMRD  = 4'd3;
  localparam logic [3:0] S_MEMWB  = 4'd4;
  localparam logic [3:0] S_MEMWR  = 4'd5;
  localparam logic [3:0] S_EXEC   = 4'd6;
  localparam logic [3:0] S_RWB    = 4'd7;
  localparam logic [3:0] S_BRANCH = 4'd8;
  localparam logic [3:0] S_JUMP   = 4'd9;
  localparam logic [3:0] S_JAL    = 4'd10;
  localparam logic [3:0] S_ADDIEX = 4'd11;
  localparam logic [3:0] S_ADDIWB = 4'd12;

  // Opcodes (instruction bits 31:26)
  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_JAL  = 6'h03;
  localparam logic [5:0] OP_ADDI = 6'h08;

  // ALU operation
  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_FUNCT = 3'b010;

  // Write-register select
  localparam logic [1:0] RD_RT  = 2'b00;
  localparam logic [1:0] RD_RD  = 2'b01;
  localparam logic [1:0] RD_R31 = 2'b10;

  // Write-data select
  localparam logic [1:0] MTR_ALU = 2'b00;
  localparam logic [1:0] MTR_MEM = 2'b01;
  localparam logic [1:0] MTR_PC  = 2'b10;

  // ALU B operand select
  localparam logic [1:0] SRCB_RT      = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SL2 = 2'b11;

  // Next-PC select
  localparam logic [1:0] PCS_ALU    = 2'b00;
  localparam logic [1:0] PCS_ALUOUT = 2'b01;
  localparam logic [1:0] PCS_JUMP   = 2'b10;

  // One state's worth of datapath controls
  typedef struct packed {
    logic       pc_en;
    logic       iord;
    logic       memread;
    logic       memwrite;
    logic       irwrite;
    logic [1:0] regdest;
    logic [1:0] memtoreg;
    logic       regwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [2:0] aluop;
    logic [1:0] pcsource;
  } ctrl_t;

endpackage

// File: rtl/ctrl_outdecode.sv
// Combinational state-to-control decoder (Moore outputs, except that the
// FETCH loads follow mem_ready and the BRANCH PC load follows the zero flag).
module ctrl_outdecode
  import ctrl_defs::*;
(
  input  logic [3:0] state,
  input  logic       mem_ready,
  input  logic       zout,
  output ctrl_t      ctrl
);

  // Every field defaults to 0; each state raises only what it uses
  always_comb begin
    ctrl = '0;
    case (state)
      S_FETCH: begin
        ctrl.memread  = 1'b1;
        ctrl.alusrcb  = SRCB_FOUR;
        ctrl.aluop    = ALU_ADD;
        ctrl.pcsource = PCS_ALU;
        ctrl.irwrite  = mem_ready;
        ctrl.pc_en    = mem_ready;
      end
      S_DECODE: begin
        ctrl.alusrcb = SRCB_IMM_SL2;
        ctrl.aluop   = ALU_ADD;
      end
      S_MEMADR, S_ADDIEX: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = SRCB_IMM;
        ctrl.aluop   = ALU_ADD;
      end
      S_MEMRD: begin
        ctrl.memread = 1'b1;
        ctrl.iord    = 1'b1;
      end
      S_MEMWB: begin
        ctrl.regwrite = 1'b1;
        ctrl.memtoreg = MTR_MEM;
        ctrl.regdest  = RD_RT;
      end
      S_MEMWR: begin
        ctrl.memwrite = 1'b1;
        ctrl.iord     = 1'b1;
      end
      S_EXEC: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = SRCB_RT;
        ctrl.aluop   = ALU_FUNCT;
      end
      S_RWB: begin
        ctrl.regwrite = 1'b1;
        ctrl.regdest  = RD_RD;
      end
      S_ADDIWB: begin
        ctrl.regwrite = 1'b1;
        ctrl.regdest  = RD_RT;
      end
      S_BRANCH: begin
        ctrl.alusrca  = 1'b1;
        ctrl.aluop    = ALU_SUB;
        ctrl.pcsource = PCS_ALUOUT;
        ctrl.pc_en    = zout;
      end
      S_JUMP: begin
        ctrl.pcsource = PCS_JUMP;
        ctrl.pc_en    = 1'b1;
      end
      S_JAL: begin
        ctrl.pcsource = PCS_JUMP;
        ctrl.pc_en    = 1'b1;
        ctrl.regwrite = 1'b1;
        ctrl.regdest  = RD_R31;
        ctrl.memtoreg = MTR_PC;
      end
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle sequencer: state register, next-state logic, reset gating of the
// enables/strobes, illegal-opcode flag and the retired-instruction counter.
module multicycle_control
  import ctrl_defs::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  opcode,
  input  logic        zout,
  input  logic        mem_ready,
  output logic        pc_en,
  output logic        iord,
  output logic        memread,
  output logic        memwrite,
  output logic        irwrite,
  output logic [1:0]  regdest,
  output logic [1:0]  memtoreg,
  output logic        regwrite,
  output logic        alusrca,
  output logic [1:0]  alusrcb,
  output logic [2:0]  aluop,
  output logic [1:0]  pcsource,
  output logic        illegal,
  output logic [3:0]  state,
  output logic [31:0] instret
);

  logic [3:0]  state_reg;
  logic [3:0]  state_next;
  logic [31:0] instret_reg;
  logic        retire;
  logic        legal;
  ctrl_t       ctrl;

  ctrl_outdecode u_outdecode (
    .state     (state_reg),
    .mem_ready (mem_ready),
    .zout      (zout),
    .ctrl      (ctrl)
  );

  // Recognise the implemented opcodes
  always_comb begin
    case (opcode)
      OP_R, OP_LW, OP_SW, OP_BEQ, OP_J, OP_JAL, OP_ADDI: legal = 1'b1;
      default:                                           legal = 1'b0;
    endcase
  end

  // Next state and retirement; every final state of an instruction returns to FETCH
  always_comb begin
    state_next = S_FETCH;
    retire     = 1'b0;
    case (state_reg)
      S_FETCH:  state_next = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (opcode)
          OP_R:         state_next = S_EXEC;
          OP_LW, OP_SW: state_next = S_MEMADR;
          OP_BEQ:       state_next = S_BRANCH;
          OP_J:         state_next = S_JUMP;
          OP_JAL:       state_next = S_JAL;
          OP_ADDI:      state_next = S_ADDIEX;
          default:      state_next = S_FETCH;
        endcase
      end
      S_MEMADR: state_next = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  state_next = mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWR: begin
        state_next = mem_ready ? S_FETCH : S_MEMWR;
        retire     = mem_ready;
      end
      S_EXEC:   state_next = S_RWB;
      S_ADDIEX: state_next = S_ADDIWB;
      S_MEMWB, S_RWB, S_ADDIWB, S_BRANCH, S_JUMP, S_JAL: begin
        state_next = S_FETCH;
        retire     = 1'b1;
      end
      default:  state_next = S_FETCH;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= S_FETCH;
    else     state_reg <= state_next;
  end

  // Retired-instruction counter, wraps naturally at 2^32
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         instret_reg <= '0;
    else if (retire) instret_reg <= instret_reg + 32'd1;
  end

  // Enables and strobes are held low for the whole reset; selects pass through
  assign pc_en    = ctrl.pc_en    & ~rst;
  assign memread  = ctrl.memread  & ~rst;
  assign memwrite = ctrl.memwrite & ~rst;
  assign irwrite  = ctrl.irwrite  & ~rst;
  assign regwrite = ctrl.regwrite & ~rst;
  assign illegal  = (state_reg == S_DECODE) & ~legal & ~rst;
  assign iord     = ctrl.iord;
  assign regdest  = ctrl.regdest;
  assign memtoreg = ctrl.memtoreg;
  assign alusrca  = ctrl.alusrca;
  assign alusrcb  = ctrl.alusrcb;
  assign aluop    = ctrl.aluop;
  assign pcsource = ctrl.pcsource;
  assign state    = state_reg;
  assign instret  = instret_reg;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: each instruction is expanded into the cycle
// trace it must produce (per-opcode step lists plus stall cycles); a single
// compare process checks every cycle of that trace against the DUT.
module tb_multicycle_control;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [5:0]  opcode = 6'h00;
  logic        zout = 1'b0;
  logic        mem_ready = 1'b0;
  logic        pc_en, iord, memread, memwrite, irwrite, regwrite, alusrca, illegal;
  logic [1:0]  regdest, memtoreg, alusrcb, pcsource;
  logic [2:0]  aluop;
  logic [3:0]  state;
  logic [31:0] instret;

  multicycle_control dut (
    .clk(clk), .rst(rst), .opcode(opcode), .zout(zout), .mem_ready(mem_ready),
    .pc_en(pc_en), .iord(iord), .memread(memread), .memwrite(memwrite),
    .irwrite(irwrite), .regdest(regdest), .memtoreg(memtoreg),
    .regwrite(regwrite), .alusrca(alusrca), .alusrcb(alusrcb), .aluop(aluop),
    .pcsource(pcsource), .illegal(illegal), .state(state), .instret(instret)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]  st;
    logic        pc_en, iord, memread, memwrite, irwrite;
    logic [1:0]  regdest, memtoreg;
    logic        regwrite, alusrca;
    logic [1:0]  alusrcb;
    logic [2:0]  aluop;
    logic [1:0]  pcsource;
    logic        illegal;
    logic [31:0] instret;
  } exp_t;

  exp_t        expq[$];
  logic [31:0] m_instret = 32'd0;
  int          tests = 0;
  int          failed = 0;
  int          cyc_cnt = 0;
  int          mw_cnt = 0;
  int          ill_cnt = 0;

  // Compare process: one expected record per driven cycle, sampled mid-cycle
  always @(negedge clk) begin : compare
    exp_t got;
    exp_t e;
    if (memwrite) mw_cnt++;
    if (illegal)  ill_cnt++;
    if (expq.size() > 0) begin
      e   = expq.pop_front();
      got = {state, pc_en, iord, memread, memwrite, irwrite, regdest, memtoreg,
             regwrite, alusrca, alusrcb, aluop, pcsource, illegal, instret};
      tests++;
      if (got !== e) begin
        failed++;
        $display("FAIL cycle_trace t=%0t state got=%0d exp=%0d word got=%h exp=%h",
                 $time, got.st, e.st, got, e);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s got=%h exp=%h", name, act, exp);
    end
  endtask

  function automatic exp_t mk(input logic [3:0] st);
    exp_t e;
    e         = '0;
    e.st      = st;
    e.instret = m_instret;
    return e;
  endfunction

  function automatic logic rbit();
    return logic'($urandom_range(0, 1));
  endfunction

  // Drive one cycle (called at posedge+1) and queue what it must look like
  task automatic cyc(input exp_t e, input logic mr, input logic z);
    mem_ready = mr;
    zout      = z;
    expq.push_back(e);
    cyc_cnt++;
    @(posedge clk);
    #1;
  endtask

  // Expand one instruction into its cycle trace
  task automatic run_instr(input logic [5:0] op, input logic z, input int fst,
                           input int mst, input bit rst_in_exec);
    exp_t e;
    bit   legal;
    opcode = op;
    legal  = op inside {6'h00, 6'h23, 6'h2B, 6'h04, 6'h02, 6'h03, 6'h08};
    for (int i = 0; i < fst; i++) begin
      e = mk(4'd0); e.memread = 1'b1; e.alusrcb = 2'd1;
      cyc(e, 1'b0, z);
    end
    e = mk(4'd0); e.memread = 1'b1; e.alusrcb = 2'd1; e.pc_en = 1'b1; e.irwrite = 1'b1;
    cyc(e, 1'b1, z);
    e = mk(4'd1); e.alusrcb = 2'd3; e.illegal = !legal;
    cyc(e, rbit(), z);
    if (!legal) return;
    case (op)
      6'h23, 6'h2B: begin
        e = mk(4'd2); e.alusrca = 1'b1; e.alusrcb = 2'd2;
        cyc(e, rbit(), z);
        if (op == 6'h23) begin
          e = mk(4'd3); e.memread = 1'b1; e.iord = 1'b1;
          for (int i = 0; i < mst; i++) cyc(e, 1'b0, z);
          cyc(e, 1'b1, z);
          e = mk(4'd4); e.regwrite = 1'b1; e.memtoreg = 2'd1;
          cyc(e, rbit(), z);
        end else begin
          e = mk(4'd5); e.memwrite = 1'b1; e.iord = 1'b1;
          for (int i = 0; i < mst; i++) cyc(e, 1'b0, z);
          cyc(e, 1'b1, z);
        end
        m_instret++;
      end
      6'h00: begin
        if (rst_in_exec) begin
          check("exec_before_reset_state", {28'd0, state}, 32'd6);
          rst = 1'b1;
          #1;
          check("midreset_state", {28'd0, state}, 32'd0);
          check("midreset_instret", instret, 32'd0);
          check("midreset_regwrite", {31'd0, regwrite}, 32'd0);
          @(posedge clk); #1;
          check("midreset_enables", {27'd0, pc_en, irwrite, memread, memwrite, regwrite}, 32'd0);
          rst = 1'b0;
          m_instret = 32'd0;
          return;
        end
        e = mk(4'd6); e.alusrca = 1'b1; e.aluop = 3'd2;
        cyc(e, rbit(), z);
        e = mk(4'd7); e.regwrite = 1'b1; e.regdest = 2'd1;
        cyc(e, rbit(), z);
        m_instret++;
      end
      6'h08: begin
        e = mk(4'd11); e.alusrca = 1'b1; e.alusrcb = 2'd2;
        cyc(e, rbit(), z);
        e = mk(4'd12); e.regwrite = 1'b1;
        cyc(e, rbit(), z);
        m_instret++;
      end
      6'h04: begin
        e = mk(4'd8); e.alusrca = 1'b1; e.aluop = 3'd1; e.pcsource = 2'd1; e.pc_en = z;
        cyc(e, rbit(), z);
        m_instret++;
      end
      6'h02: begin
        e = mk(4'd9); e.pcsource = 2'd2; e.pc_en = 1'b1;
        cyc(e, rbit(), z);
        m_instret++;
      end
      default: begin
        e = mk(4'd10); e.pcsource = 2'd2; e.pc_en = 1'b1; e.regwrite = 1'b1;
        e.regdest = 2'd2; e.memtoreg = 2'd2;
        cyc(e, rbit(), z);
        m_instret++;
      end
    endcase
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog simulation did not finish, tests=%0d failed=%0d", tests, failed);
    $fatal(1, "timeout");
  end

  initial begin : main
    int          c0;
    int          w0;
    int          i0;
    int          idx;
    logic [5:0]  op;
    logic [5:0]  ops[8];
    ops = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h02, 6'h03, 6'h08, 6'h3F};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", {28'd0, state}, 32'd0);
    check("reset_instret", instret, 32'd0);
    check("reset_enables", {27'd0, pc_en, irwrite, memread, memwrite, regwrite}, 32'd0);
    rst = 1'b0;

    // lw, no stalls: 5 cycles, one retirement
    c0 = cyc_cnt;
    run_instr(6'h23, 1'b0, 0, 0, 1'b0);
    check("lw_cycles", cyc_cnt - c0, 32'd5);
    check("lw_instret", instret, 32'd1);

    // R-type abandoned by reset in EXEC
    run_instr(6'h00, 1'b0, 0, 0, 1'b1);

    // sw with three not-ready cycles in MEMWR
    c0 = cyc_cnt; w0 = mw_cnt;
    run_instr(6'h2B, 1'b0, 0, 3, 1'b0);
    check("sw_cycles", cyc_cnt - c0, 32'd7);
    check("sw_memwrite_cycles", mw_cnt - w0, 32'd4);
    check("sw_instret", instret, 32'd1);

    // beq taken and not taken
    c0 = cyc_cnt;
    run_instr(6'h04, 1'b1, 0, 0, 1'b0);
    check("beq_taken_cycles", cyc_cnt - c0, 32'd3);
    c0 = cyc_cnt;
    run_instr(6'h04, 1'b0, 0, 0, 1'b0);
    check("beq_nottaken_cycles", cyc_cnt - c0, 32'd3);

    // jal
    run_instr(6'h03, 1'b0, 0, 0, 1'b0);
    check("jal_instret", instret, 32'd4);

    // Illegal opcode
    i0 = ill_cnt;
    run_instr(6'h3F, 1'b0, 0, 0, 1'b0);
    check("illegal_pulses", ill_cnt - i0, 32'd1);
    check("illegal_back_to_fetch", {28'd0, state}, 32'd0);
    check("illegal_instret", instret, 32'd4);

    // Counter wrap on a jump
    force dut.instret_reg = 32'hFFFF_FFFF;
    #1;
    release dut.instret_reg;
    m_instret = 32'hFFFF_FFFF;
    run_instr(6'h02, 1'b0, 1, 0, 1'b0);
    check("wrap_instret", instret, 32'd0);

    // Randomized instruction stream
    for (int n = 0; n < 60; n++) begin
      idx = int'($urandom_range(0, 8));
      if (idx == 8) op = 6'($urandom_range(0, 63));
      else          op = ops[idx];
      run_instr(op, rbit(), int'($urandom_range(0, 2)), int'($urandom_range(0, 2)), 1'b0);
    end
    check("random_instret", instret, m_instret);

    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
